pipe_muxn: RTL and testbench

//   Parametrised N:1 data selector with a registered, valid/ready-handshaked output.

---
 rtl/mux_pkg.sv | 19 +
 rtl/pipe_muxn_skid_buf.sv | 85 ++++++++
 rtl/pipe_muxn.sv | 82 ++++++++
 tb/tb_pipe_muxn.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for pipe_muxn: skid-buffer state encoding, error counter
// width and the parameter legality check used at elaboration.
package mux_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    localparam int unsigned ERRCNT_W = 16;

    // True when N is within 2..32 and SEL_W can address every input.
    function automatic bit sel_w_ok(input int unsigned n, input int unsigned sel_w);
        return (n >= 2) && (n <= 32) && (sel_w >= 1) && (sel_w <= 31) &&
               ((64'd1 << sel_w) >= 64'(n));
    endfunction

endpackage

// File: rtl/pipe_muxn_skid_buf.sv
// skid_buf: two-entry registered valid/ready stage (main register M drives the
// output, skid register S catches one word while downstream stalls).
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   in_data/in_valid     upstream payload and valid
//   in_ready             registered, low only when both entries are full
//   out_data/out_valid   contents of M and its valid flag
//   out_ready            downstream accepts
module skid_buf
    import mux_pkg::*;
#(
    parameter int unsigned W = 33
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    state_e       state_q;
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;
    logic         in_ready_q;
    logic         out_valid_q;
    logic         accept;
    logic         present;

    assign accept  = in_valid & in_ready_q;
    assign present = out_valid_q & out_ready;

    // Occupancy FSM; flags are kept registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_q      <= in_data;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && present) begin
                        main_q <= in_data;
                    end else if (accept) begin
                        skid_q     <= in_data;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_TWO;
                    end else if (present) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so only the drain path exists.
                    if (present) begin
                        main_q     <= skid_q;
                        in_ready_q <= 1'b1;
                        state_q    <= ST_ONE;
                    end
                end
                default: begin
                    state_q     <= ST_EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;

endmodule

// File: rtl/pipe_muxn.sv
// pipe_muxn: N:1 data selector with a registered valid/ready output stage.
// Out-of-range selects store zero data with sel_err set.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   in_bus [N*WIDTH]           flattened inputs, input k at [k*WIDTH +: WIDTH]
//   select [SEL_W]             input index, sampled with in_valid
//   in_valid / in_ready        upstream handshake
//   out / sel_err / out_valid  registered result, error qualifier and valid
//   out_ready                  downstream accepts
//   err_cnt [16]               only with PIPE_MUXN_ERRCNT_EN: saturating count
//                              of accepted out-of-range selects
module pipe_muxn
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N     = 5,
    parameter int unsigned SEL_W = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N*WIDTH-1:0]    in_bus,
    input  logic [SEL_W-1:0]      select,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [WIDTH-1:0]      out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  sel_err
`ifdef PIPE_MUXN_ERRCNT_EN
    ,
    output logic [ERRCNT_W-1:0]   err_cnt
`endif
);

    if (!sel_w_ok(N, SEL_W)) begin : g_bad_cfg
        $error("pipe_muxn: illegal N/SEL_W combination");
    end

    logic [WIDTH-1:0] sel_data_c;
    logic             sel_err_c;

    // Input selection; anything that matches no input yields zero with error.
    always_comb begin
        sel_data_c = '0;
        sel_err_c  = 1'b1;
        for (int unsigned k = 0; k < N; k++) begin
            if (select == SEL_W'(k)) begin
                sel_data_c = in_bus[k*WIDTH +: WIDTH];
                sel_err_c  = 1'b0;
            end
        end
    end

    skid_buf #(
        .W (WIDTH + 1)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_data   ({sel_err_c, sel_data_c}),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  ({sel_err, out}),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

`ifdef PIPE_MUXN_ERRCNT_EN
    logic [ERRCNT_W-1:0] err_cnt_q;

    // Counted at acceptance, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt_q <= '0;
        end else if (in_valid && in_ready && sel_err_c && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + ERRCNT_W'(1);
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_muxn.sv
// Bench for pipe_muxn: a 5x32 instance for directed and random traffic and an
// 8x8 instance for random traffic, both checked every cycle against a
// two-deep FIFO model of the output stage.
module tb_pipe_muxn;

    localparam int unsigned WA = 32, NA = 5, SA = 3;
    localparam int unsigned WB = 8,  NB = 8, SB = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [WA-1:0]    words_a [NA];
    logic [NA*WA-1:0] bus_a;
    logic [SA-1:0]    sel_a;
    logic             in_valid_a, in_ready_a, out_valid_a, out_ready_a, sel_err_a;
    logic [WA-1:0]    out_a;

    logic [WB-1:0]    words_b [NB];
    logic [NB*WB-1:0] bus_b;
    logic [SB-1:0]    sel_b;
    logic             in_valid_b, in_ready_b, out_valid_b, out_ready_b, sel_err_b;
    logic [WB-1:0]    out_b;

`ifdef PIPE_MUXN_ERRCNT_EN
    logic [15:0] err_cnt_a, err_cnt_b;
`endif

    for (genvar k = 0; k < NA; k++) begin : g_pack_a
        assign bus_a[k*WA +: WA] = words_a[k];
    end
    for (genvar k = 0; k < NB; k++) begin : g_pack_b
        assign bus_b[k*WB +: WB] = words_b[k];
    end

    pipe_muxn #(.WIDTH(WA), .N(NA), .SEL_W(SA)) dut_a (
        .clk       (clk),
        .reset     (reset),
        .in_bus    (bus_a),
        .select    (sel_a),
        .in_valid  (in_valid_a),
        .in_ready  (in_ready_a),
        .out       (out_a),
        .out_valid (out_valid_a),
        .out_ready (out_ready_a),
        .sel_err   (sel_err_a)
`ifdef PIPE_MUXN_ERRCNT_EN
        ,
        .err_cnt   (err_cnt_a)
`endif
    );

    pipe_muxn #(.WIDTH(WB), .N(NB), .SEL_W(SB)) dut_b (
        .clk       (clk),
        .reset     (reset),
        .in_bus    (bus_b),
        .select    (sel_b),
        .in_valid  (in_valid_b),
        .in_ready  (in_ready_b),
        .out       (out_b),
        .out_valid (out_valid_b),
        .out_ready (out_ready_b),
        .sel_err   (sel_err_b)
`ifdef PIPE_MUXN_ERRCNT_EN
        ,
        .err_cnt   (err_cnt_b)
`endif
    );

    // Reference: each DUT is a FIFO of at most two {err, data} words.
    logic [WA:0] qa [$];
    logic [WB:0] qb [$];
    int          cnt_a, cnt_b;
    bit          acc_a_last, acc_b_last;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock: update the model with pre-edge inputs, then compare outputs.
    task automatic cycle();
        bit          acc_a, pres_a, acc_b, pres_b;
        logic [WA:0] wa;
        logic [WB:0] wb;
        acc_a  = in_valid_a && (qa.size() < 2);
        pres_a = out_ready_a && (qa.size() > 0);
        acc_b  = in_valid_b && (qb.size() < 2);
        pres_b = out_ready_b && (qb.size() > 0);
        if (int'(sel_a) < int'(NA)) wa = {1'b0, words_a[sel_a]};
        else                        wa = {1'b1, {WA{1'b0}}};
        wb = {1'b0, words_b[sel_b]};
        @(posedge clk);
        if (reset) begin
            qa.delete();
            qb.delete();
            cnt_a = 0;
            cnt_b = 0;
        end else begin
            if (pres_a) void'(qa.pop_front());
            if (acc_a) begin
                qa.push_back(wa);
                if (wa[WA] && cnt_a < 65535) cnt_a++;
            end
            if (pres_b) void'(qb.pop_front());
            if (acc_b) qb.push_back(wb);
        end
        acc_a_last = acc_a && !reset;
        acc_b_last = acc_b && !reset;
        #1;
        check("a_out_valid", 64'(out_valid_a), 64'(qa.size() > 0));
        check("a_in_ready",  64'(in_ready_a),  64'(qa.size() < 2));
        if (qa.size() > 0) begin
            check("a_out",     64'(out_a),     64'(qa[0][WA-1:0]));
            check("a_sel_err", 64'(sel_err_a), 64'(qa[0][WA]));
        end
        check("b_out_valid", 64'(out_valid_b), 64'(qb.size() > 0));
        check("b_in_ready",  64'(in_ready_b),  64'(qb.size() < 2));
        if (qb.size() > 0) begin
            check("b_out",     64'(out_b),     64'(qb[0][WB-1:0]));
            check("b_sel_err", 64'(sel_err_b), 64'(1'b0));
        end
`ifdef PIPE_MUXN_ERRCNT_EN
        check("a_err_cnt", 64'(err_cnt_a), 64'(cnt_a));
        check("b_err_cnt", 64'(err_cnt_b), 64'(cnt_b));
`endif
    endtask

    initial begin
        reset       = 1'b1;
        sel_a       = '0;
        in_valid_a  = 1'b0;
        out_ready_a = 1'b1;
        sel_b       = '0;
        in_valid_b  = 1'b0;
        out_ready_b = 1'b1;
        for (int k = 0; k < int'(NA); k++) words_a[k] = 32'h1000_0000 + 32'(k);
        for (int k = 0; k < int'(NB); k++) words_b[k] = 8'(k);

        // Reset state
        cycle();
        cycle();
        check("rst_out_valid", 64'(out_valid_a), 64'd0);
        check("rst_in_ready",  64'(in_ready_a),  64'd1);
        check("rst_out",       64'(out_a),       64'd0);
        check("rst_sel_err",   64'(sel_err_a),   64'd0);
        reset = 1'b0;
        cycle();

        // Single word, select 3
        sel_a      = 3'd3;
        in_valid_a = 1'b1;
        cycle();
        in_valid_a = 1'b0;
        check("t1_out",       64'(out_a),       64'h1000_0003);
        check("t1_out_valid", 64'(out_valid_a), 64'd1);
        check("t1_sel_err",   64'(sel_err_a),   64'd0);
        cycle();

        // Back-to-back stream 0..4
        for (int i = 0; i < int'(NA); i++) begin
            sel_a      = SA'(i);
            in_valid_a = 1'b1;
            cycle();
            check("t2_out",      64'(out_a),      64'h1000_0000 + 64'(i));
            check("t2_in_ready", 64'(in_ready_a), 64'd1);
        end
        in_valid_a = 1'b0;
        cycle();

        // Out-of-range select
`ifdef PIPE_MUXN_ERRCNT_EN
        check("t3_cnt_before", 64'(err_cnt_a), 64'd0);
`endif
        sel_a      = 3'd6;
        in_valid_a = 1'b1;
        cycle();
        in_valid_a = 1'b0;
        check("t3_out",     64'(out_a),     64'd0);
        check("t3_sel_err", 64'(sel_err_a), 64'd1);
`ifdef PIPE_MUXN_ERRCNT_EN
        check("t3_cnt_after", 64'(err_cnt_a), 64'd1);
`endif
        cycle();

        // Stall with two words held
        out_ready_a = 1'b0;
        sel_a       = 3'd1;
        in_valid_a  = 1'b1;
        cycle();
        sel_a = 3'd2;
        cycle();
        in_valid_a = 1'b0;
        check("t4_in_ready", 64'(in_ready_a), 64'd0);
        check("t4_hold",     64'(out_a),      64'h1000_0001);
        cycle();
        check("t4_hold2", 64'(out_a), 64'h1000_0001);
        out_ready_a = 1'b1;
        cycle();
        check("t4_second",   64'(out_a),       64'h1000_0002);
        check("t4_valid2",   64'(out_valid_a), 64'd1);
        cycle();
        check("t4_drained",  64'(out_valid_a), 64'd0);

        // Reset while full
        out_ready_a = 1'b0;
        sel_a       = 3'd0;
        in_valid_a  = 1'b1;
        cycle();
        sel_a = 3'd4;
        cycle();
        check("t5_full", 64'(in_ready_a), 64'd0);
        in_valid_a  = 1'b0;
        out_ready_a = 1'b1;
        reset       = 1'b1;
        cycle();
        check("t5_out_valid", 64'(out_valid_a), 64'd0);
        check("t5_in_ready",  64'(in_ready_a),  64'd1);
        check("t5_out",       64'(out_a),       64'd0);
        check("t5_sel_err",   64'(sel_err_a),   64'd0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("t5_no_ghost", 64'(out_valid_a), 64'd0);
        end

        // Random traffic on both instances, honouring the hold rule
        for (int c = 0; c < 10000; c++) begin
            if (!(in_valid_a && !acc_a_last)) begin
                sel_a      = SA'($urandom_range(0, 7));
                in_valid_a = 1'($urandom_range(0, 1));
                for (int k = 0; k < int'(NA); k++) words_a[k] = $urandom;
            end
            if (!(in_valid_b && !acc_b_last)) begin
                sel_b      = SB'($urandom_range(0, 7));
                in_valid_b = 1'($urandom_range(0, 1));
                for (int k = 0; k < int'(NB); k++) words_b[k] = 8'($urandom);
            end
            out_ready_a = ($urandom_range(0, 3) != 0);
            out_ready_b = ($urandom_range(0, 2) != 0);
            reset       = ($urandom_range(0, 499) == 0);
            cycle();
        end
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
